// File: rtl/sram_arbiter_pkg.sv
// Shared types and default sizes for the SRAM arbiter and its helpers.
package sram_arbiter_pkg;

  localparam int unsigned DefAddrWidth = 15;
  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefNumReq    = 4;

  typedef enum logic [0:0] {
    StRun,
    StClear
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the first set request at or after ptr_i, wrapping around.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned PtrW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (!found && req_i[i] && (i == (32'(ptr_i) + off) % NumReq)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Multi-requester single-port SRAM arbiter with registered SRAM command and a
// full-array zero-fill sequence that takes priority over requests.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  input  logic                           clr_start,
  output logic                           clr_busy,
  output logic                           clr_done,
  output logic                           mem_sram_CEN,
  output logic                           mem_sram_GWEN,
  output logic [ADDR_WIDTH-1:0]          mem_sram_A,
  inout  wire  [DATA_WIDTH-1:0]          mem_sram_D,
  input  logic [DATA_WIDTH-1:0]          mem_sram_Q
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);

  arb_state_e state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  cen_q, cen_d, gwen_q, gwen_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [NUM_REQ-1:0]    arb_gnt, gnt, rd1_q, rd2_q;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [PtrW-1:0]       sel_ptr;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .PtrW   (PtrW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // A pending clear start wins over any request in the same cycle.
  always_comb begin
    gnt = ((state_q == StRun) && !clr_start) ? arb_gnt : '0;
  end
  assign req_ready = gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_ptr   = ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ptr   = PtrW'((i + 1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    cen_d   = 1'b1;
    gwen_d  = 1'b1;
    a_d     = a_q;
    d_d     = d_q;
    done_d  = 1'b0;
    case (state_q)
      StRun: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (|gnt) begin
          cen_d  = 1'b0;
          gwen_d = ~sel_we;
          a_d    = sel_addr;
          d_d    = sel_wdata;
          ptr_d  = sel_ptr;
        end
      end
      StClear: begin
        cen_d  = 1'b0;
        gwen_d = 1'b0;
        a_d    = cnt_q;
        d_d    = '0;
        // Stop on the last word rather than wrapping the counter.
        if (cnt_q == LastAddr) begin
          state_d = StRun;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      ptr_q   <= '0;
      cnt_q   <= '0;
      cen_q   <= 1'b1;
      gwen_q  <= 1'b1;
      a_q     <= '0;
      d_q     <= '0;
      done_q  <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      cen_q   <= cen_d;
      gwen_q  <= gwen_d;
      a_q     <= a_d;
      d_q     <= d_d;
      done_q  <= done_d;
      rd1_q   <= gnt & ~req_we;
      rd2_q   <= rd1_q;
    end
  end

  assign mem_sram_CEN  = cen_q;
  assign mem_sram_GWEN = gwen_q;
  assign mem_sram_A    = a_q;
  assign mem_sram_D    = gwen_q ? {DATA_WIDTH{1'bz}} : d_q;
  assign resp_valid    = rd2_q;
  assign resp_rdata    = mem_sram_Q;
  assign clr_busy      = (state_q == StClear);
  assign clr_done      = done_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; ADDR_WIDTH, default 15, SRAM address width; DATA_WIDTH, default 64, data width; MEM_DEPTH, default 1<<ADDR_WIDTH, words cleared by the clear sequence.
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- resp_valid  out  NUM_REQ  one-hot read-data strobe.
- resp_rdata  out  DATA_WIDTH  shared read data.
- clr_start  in  1  pulse that starts a full-array zero fill.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- mem_sram_CEN  out  1  SRAM chip enable, active-low, registered.
- mem_sram_GWEN  out  1  SRAM write enable, active-low, registered.
- mem_sram_A  out  ADDR_WIDTH  SRAM address, registered.
- mem_sram_D  inout  DATA_WIDTH  driven during write cycles, high-Z otherwise.
- mem_sram_Q  in  DATA_WIDTH  SRAM read data, valid one cycle after the SRAM read cycle.

Function
REQ-003 SHALL implement FSM states RUN and CLEAR; reset enters RUN.
REQ-004 In RUN with clr_start=0, SHALL grant at most one valid requester per cycle using round-robin; the search starts at index ptr.
REQ-005 After a grant to index g, ptr SHALL become (g+1) mod NUM_REQ; with no grant, ptr SHALL hold.
REQ-006 req_ready SHALL be 0 in CLEAR, and in any cycle where clr_start=1 (clear has priority over requests).
REQ-007 A handshake is req_valid[i]&req_ready[i] in cycle T; the SRAM command SHALL be driven in cycle T+1: CEN=0, GWEN=~we, A=addr, D=wdata if write.
REQ-008 SHALL drive CEN=1 and GWEN=1 in every cycle without a command; D SHALL be high-Z unless GWEN=0.
REQ-009 For a read accepted in cycle T, resp_valid[i] SHALL be 1 in cycle T+2 only, with resp_rdata=mem_sram_Q; writes SHALL produce no response.
REQ-010 Responses have no backpressure; back-to-back reads SHALL sustain one response per cycle.
REQ-011 Read-latency tracking SHALL be a 2-stage shift of the read grant vector, unaffected by FSM state; reads in flight at clear entry SHALL still respond.
REQ-012 clr_start in RUN SHALL enter CLEAR next cycle with counter=0; clr_start in CLEAR SHALL be ignored.
REQ-013 In CLEAR, SHALL issue one zero-write per cycle to addresses 0..MEM_DEPTH-1 in ascending order (CEN=0, GWEN=0, D=0).
REQ-014 After the write to MEM_DEPTH-1 is issued, the counter SHALL NOT wrap; the FSM SHALL return to RUN and pulse clr_done for one cycle.
REQ-015 clr_busy SHALL be 1 exactly while state=CLEAR.
REQ-016 Counter SHALL be ADDR_WIDTH bits; MEM_DEPTH SHALL be <= 1<<ADDR_WIDTH.

Reset
REQ-017 On rst_n=0, SHALL immediately set: state=RUN, ptr=0, counter=0, CEN=1, GWEN=1, A=0, D=high-Z, resp_valid=0, resp pipeline=0, clr_busy=0, clr_done=0.
REQ-018 Reset during CLEAR SHALL abort the clear with no clr_done; array contents are undefined afterwards.
REQ-019 Reset SHALL discard in-flight reads; no resp_valid after reset release until a new read handshake.

Structure
REQ-020 Shared package sram_arbiter_pkg SHALL hold the state enum (RUN, CLEAR) and default width constants (15, 64, 4).
REQ-021 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req vector, ptr; output: one-hot grant).

Verification
REQ-022 Single read: req0 reads addr 0x0010, memory preloaded 0xDEAD_BEEF_0000_0001 -> CEN=0, A=0x0010 at T+1; resp_valid=4'b0001, rdata=preload at T+2.
REQ-023 Contention: all four requesters read continuously from ptr=0 -> grants 0,1,2,3,0 in consecutive cycles; resp_valid follows the same order two cycles later.
REQ-024 Write-then-read: req2 writes 0x0123 at addr 5, then req2 reads addr 5 -> resp rdata=0x0123; no resp_valid for the write.
REQ-025 Clear with MEM_DEPTH=16 and a read in flight: clr_start -> the in-flight read still responds; 16 zero-writes to A=0..15; clr_busy high for 16 cycles; clr_done pulses once; req_ready=0 throughout; reads afterwards return 0.
REQ-026 Simultaneous events: clr_start and req_valid=4'b1111 in the same cycle -> no grant; CLEAR entered.
REQ-027 Reset mid-clear: rst_n low at counter=7 -> CEN=1, clr_busy=0, no clr_done; RUN with ptr=0 after release.
